// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, state encoding and types
// for the byte-addressable data memory.
package dmem_pkg;

  typedef logic [2:0] funct3_t;

  localparam funct3_t F3_B  = 3'b000;
  localparam funct3_t F3_H  = 3'b001;
  localparam funct3_t F3_W  = 3'b010;
  localparam funct3_t F3_BU = 3'b100;
  localparam funct3_t F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_bytewise_if.sv
// dmem_bytewise_if: valid/ready request + one-cycle response bus.
// master = load/store unit, slave = data memory.
interface dmem_bytewise_if;
  import dmem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  funct3_t     req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_load_align.sv
// dmem_load_align: funct3 + byte offset + raw word -> extended load
// data and access error (illegal funct3 or misaligned); comb only.
module dmem_load_align
  import dmem_pkg::*;
(
  input  funct3_t     funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = 8'(word_i >> {off_i, 3'b000});
  assign half_s = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    unique case (funct3_i)
      F3_B:  data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU: data_o = {24'b0, byte_s};
      F3_H: begin
        err_o  = off_i[0];
        data_o = {{16{half_s[15]}}, half_s};
      end
      F3_HU: begin
        err_o  = off_i[0];
        data_o = {16'b0, half_s};
      end
      F3_W: begin
        err_o  = (off_i != 2'b00);
        data_o = word_i;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_bytewise.sv
// dmem_bytewise: DEPTH x 32 data memory, B/H/W loads and stores,
// registered response, zero-fill walk after reset.
// Ports: clk, rst (sync, active high), bus (slave), clearing.
// `define DMEM_PERF_EN adds load_cnt/store_cnt/err_cnt outputs.
module dmem_bytewise
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_bytewise_if.slave   bus,
  output logic             clearing
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]      load_cnt,
  output logic [31:0]      store_cnt,
  output logic [31:0]      err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  state_t        state_q;
  logic [AW-1:0] clr_idx_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          accept;
  logic [31:0]   ld_data;
  logic          ld_err;
  logic          st_bad;
  logic          err_d;
  logic          do_store;
  logic [3:0]    be_d;
  logic [31:0]   wd_d;
  logic [31:0]   rdata_d;
  logic          unused_addr;

  // Upper address bits alias: memory wraps modulo 4*DEPTH.
  assign idx         = bus.req_addr[AW+1:2];
  assign off         = bus.req_addr[1:0];
  assign unused_addr = ^bus.req_addr[31:AW+2];

  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.req_ready = (state_q == ST_IDLE);
  assign clearing      = (state_q == ST_CLEAR);

  dmem_load_align u_align (
    .funct3_i (bus.req_funct3),
    .off_i    (off),
    .word_i   (mem_q[idx]),
    .data_o   (ld_data),
    .err_o    (ld_err)
  );

  // Unsigned variants exist only for loads.
  assign st_bad = bus.req_write &&
                  ((bus.req_funct3 == F3_BU) ||
                   (bus.req_funct3 == F3_HU));
  assign err_d  = ld_err || st_bad;

  assign do_store = accept && bus.req_write && !err_d && !rst;
  assign rdata_d  = (bus.req_write || err_d) ? '0 : ld_data;

  always_comb begin
    be_d = '0;
    wd_d = '0;
    unique case (bus.req_funct3)
      F3_B: begin
        be_d = 4'b0001 << off;
        wd_d = {4{bus.req_wdata[7:0]}};
      end
      F3_H: begin
        be_d = off[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{bus.req_wdata[15:0]}};
      end
      F3_W: begin
        be_d = 4'b1111;
        wd_d = bus.req_wdata;
      end
      default: begin
        be_d = '0;
        wd_d = '0;
      end
    endcase
  end

  // Array has no reset of its own; the walk zeroes it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_CLEAR) begin
      mem_q[clr_idx_q] <= '0;
    end else if (do_store) begin
      if (be_d[0]) mem_q[idx][7:0]   <= wd_d[7:0];
      if (be_d[1]) mem_q[idx][15:8]  <= wd_d[15:8];
      if (be_d[2]) mem_q[idx][23:16] <= wd_d[23:16];
      if (be_d[3]) mem_q[idx][31:24] <= wd_d[31:24];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (state_q == ST_CLEAR) begin
        clr_idx_q <= clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_q <= ST_IDLE;
        end
      end
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && err_d;
      rsp_rdata_q <= accept ? rdata_d : '0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

`ifdef DMEM_PERF_EN
  logic [31:0] load_cnt_q;
  logic [31:0] store_cnt_q;
  logic [31:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (accept) begin
      if (err_d) begin
        err_cnt_q <= err_cnt_q + 32'd1;
      end else if (bus.req_write) begin
        store_cnt_q <= store_cnt_q + 32'd1;
      end else begin
        load_cnt_q <= load_cnt_q + 32'd1;
      end
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
